// File: rtl/usb_fs_tx.sv
// USB full-speed transmitter: SYNC, NRZI bit-stuffed payload and EOP on D+/D- from a byte stream.
// Defining USB_TX_CRC16_EN appends a CRC16 over all bytes after the PID before EOP.
module usb_fs_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_dp_out,
    output logic       usb_dn_out,
    output logic       usb_oe,
    output logic       busy,
    output logic       underrun
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef USB_TX_CRC16_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, EOP_SE0, EOP_J} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          last_q, last_nxt;
    logic [2:0]    ones, ones_nxt;
    logic          lvl, lvl_nxt;
    logic          wrap, stuff_due, emit, emit_stuff, tx_bit;
`ifdef USB_TX_CRC16_EN
    logic [15:0]   crc, crc_nxt;
    logic          pid_q, pid_nxt, crc_upd, crc_in;
`endif

    assign wrap      = (cnt == CW'(CLKS_PER_BIT - 1));
    assign stuff_due = (ones == 3'd6);
    assign busy      = usb_oe;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        last_nxt    = last_q;
        lvl_nxt     = lvl;
        ones_nxt    = ones;
        emit        = 1'b0;
        emit_stuff  = 1'b0;
        tx_bit      = 1'b0;
        tx_ready    = 1'b0;
        underrun    = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_nxt     = crc;
        pid_nxt     = pid_q;
        crc_upd     = 1'b0;
        crc_in      = 1'b0;
`endif
        if (state != IDLE) cnt_nxt = wrap ? '0 : cnt + CW'(1);

        unique case (state)
            IDLE: begin
                tx_ready = ~rst;
`ifdef USB_TX_CRC16_EN
                crc_nxt  = 16'hFFFF;
                pid_nxt  = 1'b1;
`endif
                if (tx_valid) begin
                    state_nxt   = SYNC;
                    shreg_nxt   = tx_data;
                    last_nxt    = tx_last;
                    bit_idx_nxt = '0;
                    emit        = 1'b1;
                    tx_bit      = 1'b0;
                end
            end
            SYNC: if (wrap) begin
                emit = 1'b1;
                if (bit_idx == 4'd7) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                    tx_bit      = shreg[0];
                end else begin
                    bit_idx_nxt = bit_idx + 4'd1;
                    tx_bit      = (bit_idx == 4'd6);
                end
            end
            DATA: if (wrap) begin
                // Stuff takes priority, so a stuff at a byte boundary pushes the handshake out a bit time.
                if (stuff_due) begin
                    emit_stuff = 1'b1;
                end else if (bit_idx != 4'd7) begin
                    bit_idx_nxt = bit_idx + 4'd1;
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    emit        = 1'b1;
                    tx_bit      = shreg[1];
`ifdef USB_TX_CRC16_EN
                    crc_upd     = ~pid_q;
                    crc_in      = shreg[1];
`endif
                end else if (!last_q) begin
                    tx_ready = 1'b1;
                    if (tx_valid) begin
                        shreg_nxt   = tx_data;
                        last_nxt    = tx_last;
                        bit_idx_nxt = '0;
                        emit        = 1'b1;
                        tx_bit      = tx_data[0];
`ifdef USB_TX_CRC16_EN
                        pid_nxt     = 1'b0;
                        crc_upd     = 1'b1;
                        crc_in      = tx_data[0];
`endif
                    end else begin
                        underrun    = 1'b1;
                        state_nxt   = EOP_SE0;
                        bit_idx_nxt = '0;
                    end
                end else begin
                    bit_idx_nxt = '0;
`ifdef USB_TX_CRC16_EN
                    state_nxt   = CRC;
                    emit        = 1'b1;
                    tx_bit      = ~crc[0];
`else
                    state_nxt   = EOP_SE0;
`endif
                end
            end
`ifdef USB_TX_CRC16_EN
            CRC: if (wrap) begin
                if (stuff_due) begin
                    emit_stuff = 1'b1;
                end else if (bit_idx == 4'd15) begin
                    state_nxt   = EOP_SE0;
                    bit_idx_nxt = '0;
                end else begin
                    bit_idx_nxt = bit_idx + 4'd1;
                    crc_nxt     = {1'b0, crc[15:1]};
                    emit        = 1'b1;
                    tx_bit      = ~crc[1];
                end
            end
`endif
            EOP_SE0: if (wrap) begin
                if (bit_idx == 4'd1) state_nxt = EOP_J;
                else bit_idx_nxt = bit_idx + 4'd1;
            end
            EOP_J: if (wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // NRZI: a 0 toggles J/K, a 1 holds; stuffed bits are always 0.
        if (emit_stuff) begin
            lvl_nxt  = ~lvl;
            ones_nxt = '0;
        end else if (emit) begin
            lvl_nxt  = tx_bit ? lvl : ~lvl;
            ones_nxt = tx_bit ? ones + 3'd1 : 3'd0;
        end
        if (state_nxt == EOP_SE0) lvl_nxt = 1'b1;
`ifdef USB_TX_CRC16_EN
        if (crc_upd) crc_nxt = {1'b0, crc[15:1]} ^ ((crc[0] ^ crc_in) ? 16'hA001 : 16'h0000);
`endif
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            last_q     <= 1'b0;
            ones       <= '0;
            lvl        <= 1'b1;
            usb_dp_out <= 1'b1;
            usb_dn_out <= 1'b0;
            usb_oe     <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc        <= 16'hFFFF;
            pid_q      <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            last_q     <= last_nxt;
            ones       <= ones_nxt;
            lvl        <= lvl_nxt;
            usb_dp_out <= (state_nxt == EOP_SE0) ? 1'b0 : lvl_nxt;
            usb_dn_out <= (state_nxt == EOP_SE0) ? 1'b0 : ~lvl_nxt;
            usb_oe     <= (state_nxt != IDLE);
`ifdef USB_TX_CRC16_EN
            crc        <= crc_nxt;
            pid_q      <= pid_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_usb_fs_tx.sv
// Bench for usb_fs_tx: every clock of each packet is compared against a bit-level packet model.
`timescale 1ns/1ps
module tb_usb_fs_tx;
    // {oe, busy, dp, dn, ready, underrun}
    localparam logic [5:0] IDLE_VEC = 6'b001010;

    logic       clk48 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, usb_dp_out, usb_dn_out, usb_oe, busy, underrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt[$];
    logic [7:0] nq[$];
    bit         nxt_mode;
    logic [2:0] sym_q[$];   // {line level (1=J), ready at end, underrun at end}
    logic [5:0] exp_q[$];
    logic       m_lvl;
    int         m_ones;
    int         oe_clks, first_rdy, unr_cnt;

    always #10 clk48 = ~clk48;

    usb_fs_tx #(.CLKS_PER_BIT(4)) dut (
        .clk48(clk48), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .usb_dp_out(usb_dp_out), .usb_dn_out(usb_dn_out),
        .usb_oe(usb_oe), .busy(busy), .underrun(underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void add_bit(input bit b);
        if (!b) begin m_lvl = ~m_lvl; m_ones = 0; end
        else m_ones++;
        sym_q.push_back({m_lvl, 2'b00});
        if (m_ones == 6) begin
            m_lvl = ~m_lvl;
            m_ones = 0;
            sym_q.push_back({m_lvl, 2'b00});
        end
    endfunction

    function automatic void build_model(input bit last_mode);
        logic [2:0]  s;
        logic [7:0]  b;
        logic [15:0] crc;
        sym_q.delete();
        exp_q.delete();
        m_lvl = 1'b1;
        m_ones = 0;
        crc = 16'hFFFF;
        for (int i = 0; i < 8; i++) add_bit(i == 7);
        for (int k = 0; k < pkt.size(); k++) begin
            b = pkt[k];
            for (int i = 0; i < 8; i++) add_bit(b[i]);
            if (k > 0) begin
                crc = crc ^ {8'h00, b};
                for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
            end
            if (!last_mode || k != pkt.size() - 1) begin
                s = sym_q.pop_back();
                s[1] = 1'b1;
                s[0] = !last_mode && (k == pkt.size() - 1);
                sym_q.push_back(s);
            end
        end
`ifdef USB_TX_CRC16_EN
        if (last_mode) for (int i = 0; i < 16; i++) add_bit(!crc[i]);
`endif
        exp_q.push_back(IDLE_VEC);
        foreach (sym_q[n]) begin
            s = sym_q[n];
            for (int c = 0; c < 4; c++)
                exp_q.push_back({2'b11, s[2], !s[2], (c == 3) && s[1], (c == 3) && s[0]});
        end
        repeat (8) exp_q.push_back(6'b110000);
        repeat (4) exp_q.push_back(6'b111000);
    endfunction

    task automatic run_packet(input int gap, input bit last_mode, input bit hold,
                              input logic [7:0] hold_dat, input bit hold_last, input string tag);
        int         idx = 0;
        bit         take = 1'b0;
        logic [5:0] obs;
        build_model(last_mode);
        oe_clks = 0;
        first_rdy = -1;
        unr_cnt = 0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk48); #1;
            tx_valid = 1'b0;
            check({tag, " gap"}, {usb_oe, busy, usb_dp_out, usb_dn_out, tx_ready, underrun}, IDLE_VEC);
        end
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clk48); #1;
            if (take) idx++;
            if (idx < pkt.size()) begin
                tx_valid = 1'b1;
                tx_data  = pkt[idx];
                tx_last  = last_mode && (idx == pkt.size() - 1);
            end else if (hold) begin
                tx_valid = 1'b1;
                tx_data  = hold_dat;
                tx_last  = hold_last;
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end
            obs = {usb_oe, busy, usb_dp_out, usb_dn_out, tx_ready, underrun};
            check($sformatf("%s clk%0d", tag, c), obs, exp_q[c]);
            take = tx_ready && tx_valid;
            oe_clks += int'(usb_oe);
            unr_cnt += int'(underrun);
            if (tx_ready && c > 0 && first_rdy < 0) first_rdy = c - 1;
        end
        if (take) idx++;
        check({tag, " bytes taken"}, idx, pkt.size());
    endtask

    function automatic void new_random();
        int n = $urandom_range(1, 4);
        nq.delete();
        for (int i = 0; i < n; i++) nq.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        nxt_mode = ($urandom_range(0, 3) != 0);
    endfunction

    initial begin
        bit cur_mode, hold, held;

        repeat (2) @(posedge clk48);
        #1;
        check("reset outputs", {usb_oe, busy, usb_dp_out, usb_dn_out, tx_ready, underrun}, 6'b001000);
        rst = 1'b0;
        #1;
        check("idle after reset", {usb_oe, busy, usb_dp_out, usb_dn_out, tx_ready, underrun}, IDLE_VEC);

        pkt = '{8'hD2};
        run_packet(2, 1'b1, 1'b0, 8'h00, 1'b0, "single D2");
`ifdef USB_TX_CRC16_EN
        check("single D2 oe clocks", oe_clks, 140);
`else
        check("single D2 oe clocks", oe_clks, 76);
`endif

        pkt = '{8'hC3, 8'hFF};
        run_packet(2, 1'b1, 1'b0, 8'h00, 1'b0, "stuff C3 FF");
`ifndef USB_TX_CRC16_EN
        check("stuff C3 FF oe clocks", oe_clks, 112);
`endif

        pkt = '{8'h4B, 8'h00};
        run_packet(1, 1'b1, 1'b0, 8'h00, 1'b0, "ready plain");
        check("ready plain time", first_rdy, 63);
        pkt = '{8'hFC, 8'h00};
        run_packet(1, 1'b1, 1'b0, 8'h00, 1'b0, "ready stuffed");
        check("ready stuffed time", first_rdy, 67);

        pkt = '{8'h4B};
        run_packet(3, 1'b0, 1'b0, 8'h00, 1'b0, "underrun");
        check("underrun pulses", unr_cnt, 1);
        check("underrun ready time", first_rdy, 63);

        pkt = '{8'hD2};
        run_packet(2, 1'b1, 1'b1, 8'h5A, 1'b1, "b2b first");
        pkt = '{8'h5A};
        run_packet(0, 1'b1, 1'b0, 8'h00, 1'b0, "b2b second");

        pkt = '{8'hC3};
        run_packet(2, 1'b1, 1'b0, 8'h00, 1'b0, "pid C3");
`ifdef USB_TX_CRC16_EN
        check("pid C3 oe clocks", oe_clks, 140);
`else
        check("pid C3 oe clocks", oe_clks, 76);
`endif

        held = 1'b0;
        new_random();
        pkt = nq;
        cur_mode = nxt_mode;
        for (int r = 0; r < 20; r++) begin
            new_random();
            hold = cur_mode && (r != 19) && ($urandom_range(0, 1) == 1);
            run_packet(held ? 0 : $urandom_range(0, 3), cur_mode, hold, nq[0],
                       nxt_mode && (nq.size() == 1), $sformatf("rand%0d", r));
            held = hold;
            pkt = nq;
            cur_mode = nxt_mode;
        end

        @(posedge clk48); #1;
        tx_valid = 1'b1;
        tx_data  = 8'hD2;
        tx_last  = 1'b1;
        @(posedge clk48); #1;
        tx_valid = 1'b0;
        check("rst test oe rises", usb_oe, 1'b1);
        repeat (9) @(posedge clk48);
        #4;
        rst = 1'b1;
        #1;
        check("rst mid-sync", {usb_oe, busy, usb_dp_out, usb_dn_out, tx_ready, underrun}, 6'b001000);
        @(posedge clk48); #1;
        rst = 1'b0;
        #1;
        check("idle after mid reset", {usb_oe, busy, usb_dp_out, usb_dn_out, tx_ready, underrun}, IDLE_VEC);
        @(posedge clk48); #1;
        check("idle hold after reset", {usb_oe, busy, usb_dp_out, usb_dn_out, tx_ready, underrun}, IDLE_VEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
